// File: rtl/curr_ctrl_dpram_if.sv
// curr_ctrl_dpram_if: one Avalon-MM slave port of curr_ctrl_dpram
// Signals: address, byteenable, chipselect, read, write, writedata (master -> slave);
//          readdata, readdatavalid, waitrequest, err (slave -> master).
interface curr_ctrl_dpram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  logic                err;
  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest, err
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest, err
  );
endinterface

// File: rtl/curr_ctrl_dpram.sv
// curr_ctrl_dpram: dual-port Avalon-MM RAM with byte enables, write-first forwarding and freeze
// Ports: clk (rising edge), reset_n (async active-low), freeze (blocks all writes),
//        s1 / s2 (curr_ctrl_dpram_if.slave) = port A / port B.
// Optional feature: define CURR_CTRL_DPRAM_PARITY_EN for per-byte even parity and sN_err.
module curr_ctrl_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             freeze,
  curr_ctrl_dpram_if.slave s1,
  curr_ctrl_dpram_if.slave s2
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] mem [2**ADDR_W];
`ifdef CURR_CTRL_DPRAM_PARITY_EN
  logic [NB-1:0]     par [2**ADDR_W];
  logic [NB-1:0]     pr;
`endif
  logic [ADDR_W-1:0] addr [2];
  logic [NB-1:0]     be [2];
  logic [DATA_W-1:0] wdata [2];
  logic [1:0]        cs, rd, wr, acc, we, re, err_d;
  logic              wait_b;
  logic [DATA_W-1:0] rd_d [2];
  logic [RD_LAT:0]   vc [2];
  logic [RD_LAT:0]   ec [2];
  logic [DATA_W-1:0] dc [2][RD_LAT+1];
  logic [RD_LAT-1:0] v_q [2];
  logic [RD_LAT-1:0] e_q [2];
  logic [DATA_W-1:0] d_q [2][RD_LAT];
  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;
  assign cs       = {s2.chipselect, s1.chipselect};
  assign rd       = {s2.read, s1.read};
  assign wr       = {s2.write, s1.write};
  // Port B yields only when both ports write the same word in the same cycle
  assign wait_b   = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
  assign acc      = cs & (rd | wr) & {~wait_b, 1'b1};
  assign we       = acc & wr & {2{~freeze}};
  assign re       = acc & ~wr;
  // Read value sees the other port's same-cycle write lane by lane (write-first)
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p]  = mem[addr[p]];
      err_d[p] = 1'b0;
`ifdef CURR_CTRL_DPRAM_PARITY_EN
      pr = par[addr[p]];
`endif
      for (int i = 0; i < NB; i++) begin
        if (we[1-p] && addr[1-p] == addr[p] && be[1-p][i]) begin
          rd_d[p][8*i +: 8] = wdata[1-p][8*i +: 8];
`ifdef CURR_CTRL_DPRAM_PARITY_EN
          pr[i] = ^wdata[1-p][8*i +: 8];
`endif
        end
`ifdef CURR_CTRL_DPRAM_PARITY_EN
        err_d[p] = err_d[p] | (pr[i] ^ (^rd_d[p][8*i +: 8]));
`endif
      end
    end
  end
  // Stage k of the read pipeline is fed from chain entry k (entry 0 = fresh read)
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      vc[p]    = {v_q[p], re[p]};
      ec[p]    = {e_q[p], err_d[p]};
      dc[p][0] = rd_d[p];
      for (int k = 0; k < RD_LAT; k++) dc[p][k+1] = d_q[p][k];
    end
  end
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NB; i++)
        if (we[p] && be[p][i]) begin
          mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
`ifdef CURR_CTRL_DPRAM_PARITY_EN
          par[addr[p]][i] <= ^wdata[p][8*i +: 8];
`endif
        end
  end
  // Data/err stages load only with a valid read, so the last stage holds its value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        v_q[p] <= '0;
        e_q[p] <= '0;
        for (int k = 0; k < RD_LAT; k++) d_q[p][k] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < RD_LAT; k++) begin
          v_q[p][k] <= vc[p][k];
          if (vc[p][k]) begin
            d_q[p][k] <= dc[p][k];
            e_q[p][k] <= ec[p][k];
          end
        end
    end
  end
  assign s1.readdata      = d_q[0][RD_LAT-1];
  assign s2.readdata      = d_q[1][RD_LAT-1];
  assign s1.readdatavalid = v_q[0][RD_LAT-1];
  assign s2.readdatavalid = v_q[1][RD_LAT-1];
  assign s1.err           = v_q[0][RD_LAT-1] & e_q[0][RD_LAT-1];
  assign s2.err           = v_q[1][RD_LAT-1] & e_q[1][RD_LAT-1];
  assign s1.waitrequest   = 1'b0;
  assign s2.waitrequest   = wait_b;
endmodule

// File: tb/tb_curr_ctrl_dpram.sv
// tb_curr_ctrl_dpram: scoreboard bench for curr_ctrl_dpram, both ports, RD_LAT=1
module tb_curr_ctrl_dpram;
  localparam int RD_LAT = 1;
  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic freeze = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  rsp_t sb [$];
  logic [31:0] model [8];
  curr_ctrl_dpram_if #(.DATA_W(32), .ADDR_W(8)) a ();
  curr_ctrl_dpram_if #(.DATA_W(32), .ADDR_W(8)) b ();
  curr_ctrl_dpram #(.DATA_W(32), .ADDR_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze), .s1(a), .s2(b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      logic v, e;
      logic [31:0] d;
      int idx;
      v = (p == 0) ? a.readdatavalid : b.readdatavalid;
      e = (p == 0) ? a.err : b.err;
      d = (p == 0) ? a.readdata : b.readdata;
      if (v) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].port == p) idx = i;
        n_cmp++;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL unexpected_rdv port%0d got data=%h err=%b exp no response", p, d, e);
        end else begin
          if ({d, e} !== {sb[idx].data, sb[idx].err}) begin
            n_bad++;
            $display("FAIL rdata port%0d got %h/err%b exp %h/err%b", p, d, e, sb[idx].data, sb[idx].err);
          end
          n_cmp++;
          if (cyc !== sb[idx].cyc) begin
            n_bad++;
            $display("FAIL latency port%0d got cyc %0d exp cyc %0d", p, cyc, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
  task automatic idle();
    a.chipselect = 0; a.read = 0; a.write = 0; a.address = '0; a.byteenable = '0; a.writedata = '0;
    b.chipselect = 0; b.read = 0; b.write = 0; b.address = '0; b.byteenable = '0; b.writedata = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic set_wr(int p, logic [7:0] ad, logic [3:0] bv, logic [31:0] d);
    if (p == 0) begin
      a.chipselect = 1; a.write = 1; a.read = 0; a.address = ad; a.byteenable = bv; a.writedata = d;
    end else begin
      b.chipselect = 1; b.write = 1; b.read = 0; b.address = ad; b.byteenable = bv; b.writedata = d;
    end
  endtask
  task automatic set_rd(int p, logic [7:0] ad, logic [31:0] exp, bit push = 1, logic experr = 0);
    rsp_t r;
    if (p == 0) begin
      a.chipselect = 1; a.read = 1; a.write = 0; a.address = ad;
    end else begin
      b.chipselect = 1; b.read = 1; b.write = 0; b.address = ad;
    end
    r.port = p; r.data = exp; r.err = experr; r.cyc = cyc + RD_LAT;
    if (push) sb.push_back(r);
  endtask
  task automatic test_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a.readdatavalid, a.err, a.waitrequest} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags_a got %b exp 000", {a.readdatavalid, a.err, a.waitrequest});
    end
    n_cmp++;
    if ({b.readdatavalid, b.err, b.waitrequest} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags_b got %b exp 000", {b.readdatavalid, b.err, b.waitrequest});
    end
    n_cmp++;
    if (a.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_a got %h exp 0", a.readdata); end
    n_cmp++;
    if (b.readdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata_b got %h exp 0", b.readdata); end
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_write_read();
    set_wr(0, 8'h10, 4'hF, 32'hA5A51234); step();
    set_rd(1, 8'h10, 32'hA5A51234); set_rd(0, 8'h10, 32'hA5A51234); step();
    repeat (RD_LAT) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({b.readdatavalid, b.readdata} !== {1'b0, 32'hA5A51234}) begin
      n_bad++; $display("FAIL hold_b got v=%b d=%h exp v=0 d=a5a51234", b.readdatavalid, b.readdata);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_byte_lanes();
    set_wr(0, 8'h20, 4'hF, 32'h11223344); step();
    set_wr(0, 8'h20, 4'h3, 32'hFFFFAABB); step();
    set_rd(1, 8'h20, 32'h1122AABB); step();
    set_wr(1, 8'h20, 4'h8, 32'hCC000000); step();
    set_rd(0, 8'h20, 32'hCC22AABB); step();
  endtask
  task automatic test_rw_both();
    set_wr(0, 8'h21, 4'hF, 32'h12345678); a.read = 1; step();
    set_rd(0, 8'h21, 32'h12345678); step();
  endtask
  task automatic test_collision();
    set_wr(0, 8'h05, 4'hF, 32'h1); set_wr(1, 8'h05, 4'hF, 32'h2);
    #1;
    n_cmp++;
    if ({a.waitrequest, b.waitrequest} !== 2'b01) begin
      n_bad++; $display("FAIL collide_wait got a=%b b=%b exp a=0 b=1", a.waitrequest, b.waitrequest);
    end
    @(posedge clk);
    #1;
    a.chipselect = 0; a.write = 0;
    #1;
    n_cmp++;
    if (b.waitrequest !== 1'b0) begin n_bad++; $display("FAIL collide_release got %b exp 0", b.waitrequest); end
    step();
    set_rd(0, 8'h05, 32'h2); set_rd(1, 8'h05, 32'h2); step();
    set_wr(0, 8'h06, 4'hF, 32'h6); set_wr(1, 8'h07, 4'hF, 32'h7);
    #1;
    n_cmp++;
    if (b.waitrequest !== 1'b0) begin n_bad++; $display("FAIL diff_addr_wait got %b exp 0", b.waitrequest); end
    step();
    set_rd(0, 8'h07, 32'h7); set_rd(1, 8'h06, 32'h6); step();
  endtask
  task automatic test_freeze();
    set_wr(1, 8'h30, 4'hF, 32'h0); step();
    freeze = 1;
    set_wr(1, 8'h30, 4'hF, 32'hDEADBEEF); set_rd(0, 8'h30, 32'h0);
    #1;
    n_cmp++;
    if (b.waitrequest !== 1'b0) begin n_bad++; $display("FAIL freeze_wait got %b exp 0", b.waitrequest); end
    step();
    set_wr(0, 8'h30, 4'hF, 32'hDEADBEEF); step();
    freeze = 0;
    set_rd(1, 8'h30, 32'h0); step();
  endtask
  task automatic test_forward();
    set_wr(0, 8'h60, 4'hF, 32'h01020304); step();
    set_wr(0, 8'h60, 4'h5, 32'hAABBCCDD); set_rd(1, 8'h60, 32'h01BB03DD); step();
    set_wr(1, 8'h60, 4'hA, 32'h11223344); set_rd(0, 8'h60, 32'h11BB33DD); step();
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_wr(0, 8'h70 + 8'(i), 4'hF, 32'h70000000 + 32'(i));
      set_wr(1, 8'h74 + 8'(i), 4'hF, 32'h74000000 + 32'(i));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_rd(0, 8'h74 + 8'(i), 32'h74000000 + 32'(i));
      set_rd(1, 8'h70 + 8'(i), 32'h70000000 + 32'(i));
      step();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      set_wr(0, {5'b10000, 3'(i)}, 4'hF, model[i]);
      step();
    end
    for (int c = 0; c < 120; c++) begin
      int op [2];
      logic [2:0] ad [2];
      logic [3:0] bv [2];
      logic [31:0] dv [2];
      freeze = ($urandom_range(7) == 0);
      for (int p = 0; p < 2; p++) begin
        op[p] = int'($urandom_range(2));
        ad[p] = 3'($urandom_range(7));
        bv[p] = 4'($urandom);
        dv[p] = $urandom;
      end
      if (op[0] == 2 && op[1] == 2 && ad[0] == ad[1]) op[1] = 1;
      for (int p = 0; p < 2; p++)
        if (op[p] == 2) begin
          set_wr(p, {5'b10000, ad[p]}, bv[p], dv[p]);
          if (!freeze)
            for (int l = 0; l < 4; l++) if (bv[p][l]) model[ad[p]][8*l +: 8] = dv[p][8*l +: 8];
        end
      for (int p = 0; p < 2; p++) if (op[p] == 1) set_rd(p, {5'b10000, ad[p]}, model[ad[p]]);
      step();
    end
    freeze = 0;
  endtask
  task automatic test_parity();
`ifdef CURR_CTRL_DPRAM_PARITY_EN
    set_wr(0, 8'h50, 4'hF, 32'h5A5A5A5A); step();
    set_wr(0, 8'h51, 4'hF, 32'h0F0F0F0F); step();
    dut.mem[8'h50][0] = ~dut.mem[8'h50][0];
    set_rd(0, 8'h50, 32'h5A5A5A5B, 1, 1'b1); set_rd(1, 8'h51, 32'h0F0F0F0F, 1, 1'b0); step();
`endif
  endtask
  task automatic test_reset_flight();
    set_wr(0, 8'h40, 4'hF, 32'hCAFEF00D); step();
    set_rd(0, 8'h40, 32'h0, 0);
    @(posedge clk);
    #1;
    idle();
    reset_n = 0;
    #1;
    n_cmp++;
    if ({a.readdatavalid, a.readdata} !== 33'h0) begin
      n_bad++; $display("FAIL flight_reset got v=%b d=%h exp v=0 d=0", a.readdatavalid, a.readdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    set_rd(1, 8'h40, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a.readdatavalid, a.readdata} !== 33'h0) begin
        n_bad++; $display("FAIL flight_after got v=%b d=%h exp v=0 d=0", a.readdatavalid, a.readdata);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain got %0d pending exp 0", sb.size()); end
  endtask
  initial begin
    idle();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_rw_both();
    test_collision();
    test_freeze();
    test_forward();
    test_back_to_back();
    test_random();
    test_parity();
    test_reset_flight();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
